adder_issue_stage: RTL and testbench
====================================

// Module: adder_issue_stage
// PURPOSE
//  Handshaked issue/capture stage wrapped around the 32-bit ripple-carry adder (rippleCarryAdder32).
//  - Accepts an operand pair over valid/ready and holds it stable on the adder inputs for SETTLE_CYCLES.
//  - This treats the long ripple chain as a multicycle path.
//  - Then registers sum/carry/overflow and presents the result downstream over valid/ready.
//  - Sits between the operand source (register file / test driver) and the result consumer.
// PARAMETERS
//  WIDTH          32  operand width; fixed at 32 to match the adder; any other value is an elaboration error
//  SETTLE_CYCLES  2   cycles operands are held before capture; legal 1..15, 0 is an elaboration error
//  CNT_W          4   width of the settle counter
// PORTS
//  clk        in   1   single clock, rising edge
//  rst_n      in   1   synchronous, active-low reset
//  in_valid   in   1   operand pair valid
//  in_ready   out  1   stage can accept operands this cycle
//  in_a       in   32  operand A
//  in_b       in   32  operand B
//  out_valid  out  1   result valid
//  out_ready  in   1   consumer accepts result
//  out_sum    out  32  registered sum
//  out_cout   out  1   registered carry-out of bit 31
//  out_ovf    out  1   registered signed overflow
//  done_cnt   out  16  completed-result counter (wraps)
//  ovf_sticky out  1   [STICKY_OVF_EN only] sticky overflow flag
//  ovf_clr    in   1   [STICKY_OVF_EN only] clear sticky flag
// BEHAVIOUR
//  Clock and reset:
//  - One clock (clk); reset is synchronous and active-low (rst_n).
//  - Reset: state=IDLE, out_valid=0, out_sum=0, out_cout=0, out_ovf=0, done_cnt=0, ovf_sticky=0, operand regs=0.
//  - Reset is honoured in any state. A pending or settling operation is discarded, and out_valid never rises for it.
//  FSM states: IDLE, SETTLE, HOLD.
//  - in_ready = (state==IDLE) | (state==HOLD & out_ready). Combinational; no in_valid->in_ready path.
//  - IDLE: on in_valid&in_ready, latch in_a/in_b into the operand regs, set cnt<=SETTLE_CYCLES-1, go to SETTLE.
//  - SETTLE: operand regs are frozen and the adder Cin is tied 0.
//    - cnt!=0: cnt decrements.
//    - cnt==0: capture S/Cout/overFlow into the out_* regs, set out_valid<=1, done_cnt+=1, go to HOLD.
//  - HOLD: out_* stable while out_valid=1 and out_ready=0.
//    - out_ready=1, in_valid=0: out_valid<=0, go to IDLE.
//    - out_ready=1, in_valid=1: same-edge handoff. Drop the old result, accept the new operands, go to SETTLE (out_valid<=0).
//  Timing:
//  - Latency: operands accepted at edge k -> out_valid high after edge k+SETTLE_CYCLES.
//  - Throughput: at most one result per SETTLE_CYCLES+1 cycles.
//  - in_valid while in SETTLE (or HOLD without out_ready) is ignored. The source must hold its data (standard valid/ready).
//  - out_sum/out_cout/out_ovf keep their last captured values after out_valid drops; they are cleared only by reset.
//  Arithmetic:
//  - Unsigned carry: out_cout = carry out of bit 31.
//  - Signed overflow: out_ovf=1 iff A[31]==B[31] and S[31]!=A[31].
//  - Sum wraps mod 2^32. done_cnt wraps 0xFFFF->0x0000.
// CONFIGURATION
//  Macro STICKY_OVF_EN.
//  - Defined: ovf_sticky/ovf_clr ports exist.
//    - ovf_sticky<=1 on any capture edge with overflow=1.
//    - ovf_clr=1 clears the flag. If set and clear occur on the same edge, set wins.
//  - Undefined: both ports are absent and no sticky register is built.
// STRUCTURE
//  - Shared package adder_pkg: WIDTH=32 constant, state enum typedef {IDLE,SETTLE,HOLD}.
//  - One sub-module instance: rippleCarryAdder32 (A/B from the operand regs, Cin=0).
//  - FSM, counters and result regs are local to this module.
// TESTING
//  1. Reset: rst_n=0 for 2 cycles -> out_valid=0, in_ready=1, out_sum=0, done_cnt=0.
//  2. SETTLE=2, a=0x5, b=0x3 accepted at edge k -> out_valid=1 after edge k+2; sum=0x8, cout=0, ovf=0, done_cnt=1.
//  3. a=0x7FFFFFFF, b=0x1 -> sum=0x80000000, ovf=1, cout=0; ovf_sticky=1 (macro on).
//     Then ovf_clr together with another overflowing capture -> ovf_sticky stays 1.
//  4. a=0xFFFFFFFF, b=0x1 -> sum=0x0, cout=1, ovf=0.
//     a=0x80000000, b=0x80000000 -> sum=0x0, cout=1, ovf=1.
//  5. Backpressure: out_ready=0 for 5 cycles with in_valid=1 -> out_* stable, in_ready=0, nothing accepted.
//     Then out_ready=1 -> same-edge handoff, next result SETTLE_CYCLES later.
//  6. Reset mid-SETTLE -> state IDLE, out_valid stays 0, done_cnt=0; the next op completes normally.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared definitions for the adder issue stage: datapath width and the
// issue-stage FSM state encoding.
package adder_pkg;

  localparam int WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } state_t;

endpackage

// File: rtl/adder_issue_stage_rca.sv
// rippleCarryAdder32: plain 32-bit ripple-carry adder built from one full
// adder per bit. Purely combinational; the carry chain is long, so the issue
// stage treats it as a multicycle path. overFlow is the signed overflow,
// computed as the XOR of the carries into and out of bit 31.
module rippleCarryAdder32 (
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        Cin,
  output logic [31:0] S,
  output logic        Cout,
  output logic        overFlow
);

  logic [32:0] c;

  // Bit-serial carry propagation, LSB to MSB.
  always_comb begin
    S        = '0;
    c        = '0;
    c[0]     = Cin;
    for (int i = 0; i < 32; i++) begin
      S[i]     = A[i] ^ B[i] ^ c[i];
      c[i + 1] = (A[i] & B[i]) | (c[i] & (A[i] ^ B[i]));
    end
    Cout     = c[32];
    overFlow = c[32] ^ c[31];
  end

endmodule

// File: rtl/adder_issue_stage.sv
// adder_issue_stage: valid/ready issue and capture wrapper around
// rippleCarryAdder32. Operands are latched, held stable for SETTLE_CYCLES
// cycles while the ripple chain settles, then sum/carry/overflow are
// registered and offered downstream.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. in_ready depends only on state and out_ready (never on in_valid);
// out_* are held stable while out_valid=1 and out_ready=0. A source must
// hold its data until it is accepted.
//
// Optional feature: define STICKY_OVF_EN to add the ovf_sticky/ovf_clr
// ports and the sticky overflow register.
module adder_issue_stage
  import adder_pkg::*;
#(
  parameter int WIDTH         = adder_pkg::WIDTH,
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_W         = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic [15:0]      done_cnt,
`ifdef STICKY_OVF_EN
  output logic             ovf_sticky,
  input  logic             ovf_clr,
`endif
  output state_t           dbg_state
);

  // Configuration guards: the adder is fixed at 32 bits and the settle
  // counter must be able to hold SETTLE_CYCLES-1.
  if (WIDTH != 32) begin : g_bad_width
    $error("adder_issue_stage: WIDTH must be 32");
  end
  if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
    $error("adder_issue_stage: SETTLE_CYCLES must be in 1..15");
  end
  if ((SETTLE_CYCLES - 1) >= (1 << CNT_W)) begin : g_bad_cnt_w
    $error("adder_issue_stage: CNT_W too narrow for SETTLE_CYCLES");
  end

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(SETTLE_CYCLES - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      a_q, a_d;
  logic [31:0]      b_q, b_d;
  logic [31:0]      sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             valid_q, valid_d;
  logic [15:0]      done_q, done_d;
  logic             capture;

  logic [31:0]      add_s;
  logic             add_cout;
  logic             add_ovf;

  // The adder sees only the frozen operand registers; Cin is always 0.
  rippleCarryAdder32 u_rca (
    .A        (a_q),
    .B        (b_q),
    .Cin      (1'b0),
    .S        (add_s),
    .Cout     (add_cout),
    .overFlow (add_ovf)
  );

  // Ready whenever idle, or when the held result leaves on this same edge.
  always_comb begin
    in_ready = (state_q == IDLE) | ((state_q == HOLD) & out_ready);
  end

  // Next-state, operand latch, settle countdown and result capture.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    valid_d = valid_q;
    done_d  = done_q;
    capture = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_b;
          cnt_d   = CNT_INIT;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          capture = 1'b1;
          sum_d   = add_s;
          cout_d  = add_cout;
          ovf_d   = add_ovf;
          valid_d = 1'b1;
          done_d  = done_q + 16'd1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          valid_d = 1'b0;
          if (in_valid) begin
            // Same-edge handoff: old result leaves, new operands enter.
            a_d     = in_a;
            b_d     = in_b;
            cnt_d   = CNT_INIT;
            state_d = SETTLE;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  // State and datapath registers; reset discards any in-flight operation.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

`ifdef STICKY_OVF_EN
  logic sticky_q, sticky_d;

  // Sticky overflow: a capture with overflow beats a simultaneous clear.
  always_comb begin
    sticky_d = sticky_q;
    if (ovf_clr) begin
      sticky_d = 1'b0;
    end
    if (capture && add_ovf) begin
      sticky_d = 1'b1;
    end
  end

  // Sticky overflow register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sticky_q <= 1'b0;
    end else begin
      sticky_q <= sticky_d;
    end
  end

  assign ovf_sticky = sticky_q;
`endif

  assign out_valid = valid_q;
  assign out_sum   = sum_q;
  assign out_cout  = cout_q;
  assign out_ovf   = ovf_q;
  assign done_cnt  = done_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_adder_issue_stage.sv
// Bench for adder_issue_stage. A transaction-level model (accept timestamps,
// 33-bit arithmetic) predicts every output on every cycle; directed sequences
// add literal expectations for the key arithmetic and timing cases.
module tb_adder_issue_stage;
  import adder_pkg::*;

  localparam int S = 2;

  // Clock and reset
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_sum;
  logic        out_cout;
  logic        out_ovf;
  logic [15:0] done_cnt;
  state_t      dbg_state;
`ifdef STICKY_OVF_EN
  logic        ovf_sticky;
  logic        ovf_clr = 1'b0;
`endif

  always #5 clk = ~clk;

  adder_issue_stage #(.SETTLE_CYCLES(S)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_ovf   (out_ovf),
    .done_cnt  (done_cnt),
`ifdef STICKY_OVF_EN
    .ovf_sticky(ovf_sticky),
    .ovf_clr   (ovf_clr),
`endif
    .dbg_state (dbg_state)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: an operation accepted at cycle c produces its result
  // at cycle c+S; it stays visible until consumed by out_ready.
  longint      cyc = 0;
  bit          m_ok = 1'b0;
  bit          m_have = 1'b0;
  bit          m_vis = 1'b0;
  logic [31:0] m_a = '0;
  logic [31:0] m_b = '0;
  longint      m_acc = 0;
  logic [31:0] m_sum = '0;
  bit          m_cout = 1'b0;
  bit          m_ovf = 1'b0;
  bit          m_sticky = 1'b0;
  logic [15:0] m_done = '0;

  always @(posedge clk) begin : model
    bit          have0, vis0, rdy, acc, cap;
    logic [32:0] full;
    cyc++;
    if (!rst_n) begin
      m_ok = 1'b1; m_have = 1'b0; m_vis = 1'b0;
      m_a = '0; m_b = '0; m_sum = '0; m_cout = 1'b0; m_ovf = 1'b0;
      m_sticky = 1'b0; m_done = '0;
    end else if (m_ok) begin
      have0 = m_have;
      vis0  = m_vis;
      rdy   = !have0 || (vis0 && out_ready);
      acc   = in_valid && rdy;
      cap   = have0 && !vis0 && (cyc == m_acc + S);
      if (cap) begin
        full   = {1'b0, m_a} + {1'b0, m_b};
        m_sum  = full[31:0];
        m_cout = full[32];
        m_ovf  = (m_a[31] == m_b[31]) && (full[31] != m_a[31]);
        m_done = m_done + 16'd1;
        m_vis  = 1'b1;
      end
`ifdef STICKY_OVF_EN
      if (cap && m_ovf) m_sticky = 1'b1;
      else if (ovf_clr) m_sticky = 1'b0;
`endif
      if (vis0 && out_ready) begin
        m_have = 1'b0;
        m_vis  = 1'b0;
      end
      if (acc) begin
        m_have = 1'b1; m_vis = 1'b0;
        m_a = in_a; m_b = in_b; m_acc = cyc;
      end
    end
  end

  // Scoreboard: compare every output against the model on each falling edge.
  always @(negedge clk) begin
    if (m_ok) begin
      chk("out_valid", 32'(out_valid), 32'(m_vis));
      chk("in_ready", 32'(in_ready), 32'(!m_have || (m_vis && out_ready)));
      chk("out_sum", out_sum, m_sum);
      chk("out_cout", 32'(out_cout), 32'(m_cout));
      chk("out_ovf", 32'(out_ovf), 32'(m_ovf));
      chk("done_cnt", 32'(done_cnt), 32'(m_done));
      chk("state", 32'(dbg_state),
          32'(!m_have ? IDLE : (m_vis ? HOLD : SETTLE)));
`ifdef STICKY_OVF_EN
      chk("ovf_sticky", 32'(ovf_sticky), 32'(m_sticky));
`endif
    end
  end

  // Driver tasks
  task automatic issue(input logic [31:0] a, input logic [31:0] b);
    bit taken;
    taken = 1'b0;
    in_a = a; in_b = b; in_valid = 1'b1;
    for (int i = 0; i < 50 && !taken; i++) begin
      @(negedge clk);
      taken = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!taken) chk("issue_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (n < 50) begin
      @(negedge clk);
      n++;
      if (out_valid) break;
    end
    if (!out_valid) chk("valid_timeout", 32'd0, 32'd1);
  endtask

  task automatic pop();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic expect_result(input string name, input logic [31:0] sum,
                               input bit cout, input bit ovf);
    int n;
    wait_valid(n);
    chk({name, "_latency"}, 32'(n), 32'(S + 1));
    chk({name, "_sum"}, out_sum, sum);
    chk({name, "_cout"}, 32'(out_cout), 32'(cout));
    chk({name, "_ovf"}, 32'(out_ovf), 32'(ovf));
  endtask

  logic [31:0] stream_a [6] = '{32'h0000_0001, 32'h1234_5678, 32'hFFFF_FFFF,
                                32'h7FFF_0000, 32'h8000_0001, 32'h0000_0000};
  logic [31:0] stream_b [6] = '{32'h0000_0002, 32'h8765_4321, 32'hFFFF_FFFF,
                                32'h0001_0000, 32'hFFFF_FFFF, 32'h0000_0000};

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    // Reset for two cycles
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_sum", out_sum, 32'd0);
    chk("rst_done_cnt", 32'(done_cnt), 32'd0);
    @(posedge clk);
    #1;

    // Basic add and latency
    issue(32'h5, 32'h3);
    expect_result("add5p3", 32'h8, 1'b0, 1'b0);
    chk("add5p3_done", 32'(done_cnt), 32'd1);
    pop();

    // Positive overflow
    issue(32'h7FFF_FFFF, 32'h1);
    expect_result("posovf", 32'h8000_0000, 1'b0, 1'b1);
`ifdef STICKY_OVF_EN
    chk("sticky_set", 32'(ovf_sticky), 32'd1);
`endif
    pop();

`ifdef STICKY_OVF_EN
    // Clear held across another overflowing capture: set wins
    ovf_clr = 1'b1;
    issue(32'h7FFF_FFFF, 32'h7FFF_FFFF);
    expect_result("setwins", 32'hFFFF_FFFE, 1'b0, 1'b1);
    ovf_clr = 1'b0;
    chk("sticky_setwins", 32'(ovf_sticky), 32'd1);
    pop();
    ovf_clr = 1'b1;
    @(posedge clk);
    #1;
    ovf_clr = 1'b0;
    @(negedge clk);
    chk("sticky_cleared", 32'(ovf_sticky), 32'd0);
    @(posedge clk);
    #1;
`endif

    // Unsigned carry and negative overflow
    issue(32'hFFFF_FFFF, 32'h1);
    expect_result("carry", 32'h0, 1'b1, 1'b0);
    pop();
    issue(32'h8000_0000, 32'h8000_0000);
    expect_result("negovf", 32'h0, 1'b1, 1'b1);
    pop();

    // Backpressure with a waiting operand, then same-edge handoff
    issue(32'd10, 32'd20);
    expect_result("bp_first", 32'd30, 1'b0, 1'b0);
    in_a = 32'd100; in_b = 32'd23; in_valid = 1'b1; out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_out_sum", out_sum, 32'd30);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    expect_result("handoff", 32'd123, 1'b0, 1'b0);
    pop();

    // Back-to-back stream with the consumer always ready
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) issue(stream_a[i], stream_b[i]);
    repeat (S + 3) @(posedge clk);
    #1;
    out_ready = 1'b0;

    // Reset in the middle of SETTLE
    issue(32'h1, 32'h2);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_done", 32'(done_cnt), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("midrst_valid_low", 32'(out_valid), 32'd0);
    end
    @(posedge clk);
    #1;
    issue(32'd9, 32'd6);
    expect_result("after_rst", 32'd15, 1'b0, 1'b0);
    chk("after_rst_done", 32'(done_cnt), 32'd1);
    pop();

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
